multicycle_cu: RTL
==================

Name: multicycle_cu

Overview:
- Main control FSM for the multi-cycle RV32I datapath variant.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the 3-bit aluop, encoded per RISCV_PKG.vh, into the ALU control decoder.
- Sequences the handshakes with instruction memory and data memory, and serialises one shared ALU across those phases.

Parameters:
MEM_TIMEOUT, 16, cycles a memory request may wait for ready before FAULT; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from IR
branch_taken  in  1  ALU compare result, valid in EXEC
imem_ready  in  1  instruction memory ack
dmem_ready  in  1  data memory ack
imem_req  out  1  fetch request
ir_write  out  1  latch instruction into IR
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (stores)
aluop  out  3  `R_TYPE/`I_TYPE/`LOAD/`STORE/`BRANCH/`JUMP/`U_TYPE/`NOP
alu_src_a  out  2  0=rs1, 1=pc, 2=zero
alu_src_b  out  1  0=rs2, 1=imm
reg_write  out  1  register file write enable
wb_sel  out  1  0=ALU result, 1=load data
pc_write  out  1  PC update strobe
pc_sel  out  2  0=pc+4, 1=pc+imm, 2=(rs1+imm)&~1
retire  out  1  one-cycle pulse per completed instruction
fault  out  1  sticky error flag
state  out  3  current state (debug)

Behaviour:
States and encodings:
- RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.

Reset:
- rst_n low forces state RST and clears the timeout counter.
- Every output is 0 in RST; aluop=`NOP.
- RST moves to FETCH on the first clk edge with rst_n high.

FETCH:
- imem_req=1 and is held until imem_ready.
- ir_write = imem_ready (Mealy, same cycle).
- On imem_ready, go to DECODE.

DECODE:
- Lasts exactly 1 cycle; no strobes.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Legal goes to EXEC.
- Any other opcode goes to FAULT.

EXEC (aluop, alu_src_a/b):
- R: `R_TYPE, 0/0, then WB.
- I-ALU: `I_TYPE, 0/1, then WB.
- LOAD: `LOAD, 0/1, then MEM.
- STORE: `STORE, 0/1, then MEM.
- LUI: `U_TYPE, 2/1, then WB.
- AUIPC: `U_TYPE, 1/1, then WB.
- JAL/JALR: `JUMP, 1/0, then WB.
- BRANCH: `BRANCH, 0/0, then:
  - pc_write=1, pc_sel = branch_taken ? 1 : 0, retire=1, go to FETCH.

MEM:
- dmem_req=1, and dmem_we=1 for stores; aluop and sources are held from EXEC so the address stays stable.
- On dmem_ready, LOAD goes to WB.
- On dmem_ready, STORE asserts pc_write=1, pc_sel=0, retire=1 and goes to FETCH.

WB:
- reg_write=1 and pc_write=1 for one cycle, then FETCH; retire=1.
- wb_sel=1 only for LOAD.
- pc_sel = 1 for JAL, 2 for JALR, 0 otherwise.
- aluop and sources are held from EXEC.

Timeout:
- A counter clears on entry to FETCH or MEM and increments each cycle that ready is low.
- When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with ready still low, go to FAULT. Ready arriving in that same cycle wins.

FAULT:
- fault=1; every strobe 0; aluop=`NOP.
- Exited only by reset.

Latency with zero-wait memory:
- ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.
- Each wait cycle adds 1.

Invariants:
- Never more than one of reg_write, dmem_req or imem_req high at once.
- Exactly one retire per instruction.
- Reset asserted mid-instruction aborts immediately; no strobe may glitch after rst_n falls.

Test Plan:
1. Reset held 3 cycles, then released; imem_ready=1, ADD opcode 0110011 -> state sequence 0,1,2,3,5,1; aluop=`R_TYPE in EXEC; reg_write=1 and retire=1 only in WB.
2. LW (0000011) with dmem_ready low 2 cycles, then high -> MEM lasts 3 cycles with dmem_req=1 and dmem_we=0; WB has wb_sel=1; total 7 cycles.
3. BEQ (1100011) with branch_taken=1, then repeated with branch_taken=0 -> first run: pc_sel=1, pc_write=1 in EXEC; second run: pc_sel=0; each returns to FETCH after 3 cycles; no reg_write.
4. JALR (1100111) -> EXEC aluop=`JUMP with alu_src_a=1; WB has reg_write=1, pc_sel=2.
5. imem_ready held low, MEM_TIMEOUT=16 -> FAULT entered after 16 wait cycles, fault=1, all strobes 0; stays in FAULT until rst_n pulsed low, then RST, then FETCH.
6. Illegal opcode 1111111 -> DECODE goes to FAULT; also: rst_n dropped mid-MEM of a store -> dmem_req and dmem_we go to 0 immediately (async); state=0.

Source files
------------

// File: rtl/multicycle_cu.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences FETCH, DECODE,
// EXEC, MEM and WB, drives ALU/datapath controls and handles memory handshakes.
module multicycle_cu #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [2:0] aluop,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] BRANCH = 3'd4;
    localparam logic [2:0] JUMP   = 3'd5;
    localparam logic [2:0] U_TYPE = 3'd6;
    localparam logic [2:0] NOP    = 3'd7;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        RST    = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } cls_t;

    state_t         cur, nxt;
    cls_t           dec_cls, cls_q;
    logic [CW-1:0]  cnt;
    logic           waiting;
    logic           tmo_hit;
    logic [2:0]     ex_aluop;
    logic [1:0]     ex_a;
    logic           ex_b;

    always_comb begin
        dec_cls = C_ILL;
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_cls = C_ILL;
        endcase
    end

    // ALU setup is derived from the class latched in DECODE so it stays stable through MEM/WB
    always_comb begin
        ex_aluop = NOP;
        ex_a     = 2'd0;
        ex_b     = 1'b0;
        case (cls_q)
            C_R:      begin ex_aluop = R_TYPE; ex_a = 2'd0; ex_b = 1'b0; end
            C_I:      begin ex_aluop = I_TYPE; ex_a = 2'd0; ex_b = 1'b1; end
            C_LOAD:   begin ex_aluop = LOAD;   ex_a = 2'd0; ex_b = 1'b1; end
            C_STORE:  begin ex_aluop = STORE;  ex_a = 2'd0; ex_b = 1'b1; end
            C_BRANCH: begin ex_aluop = BRANCH; ex_a = 2'd0; ex_b = 1'b0; end
            C_JAL:    begin ex_aluop = JUMP;   ex_a = 2'd1; ex_b = 1'b0; end
            C_JALR:   begin ex_aluop = JUMP;   ex_a = 2'd1; ex_b = 1'b0; end
            C_LUI:    begin ex_aluop = U_TYPE; ex_a = 2'd2; ex_b = 1'b1; end
            C_AUIPC:  begin ex_aluop = U_TYPE; ex_a = 2'd1; ex_b = 1'b1; end
            default:  begin ex_aluop = NOP;    ex_a = 2'd0; ex_b = 1'b0; end
        endcase
    end

    assign waiting = ((cur == FETCH) && !imem_ready) || ((cur == MEM) && !dmem_ready);
    assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= RST;
            cnt   <= '0;
            cls_q <= C_ILL;
        end else begin
            cur <= nxt;
            // a state change always lands in a fresh wait window (covers MEM->FETCH for stores)
            if (nxt != cur)
                cnt <= '0;
            else if (waiting)
                cnt <= cnt + 1'b1;
            if (cur == DECODE)
                cls_q <= dec_cls;
        end
    end

    always_comb begin
        nxt       = cur;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        aluop     = NOP;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 2'd0;
        retire    = 1'b0;
        fault     = 1'b0;
        case (cur)
            RST: nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                if (imem_ready)
                    nxt = DECODE;
                else if (tmo_hit)
                    nxt = FAULT;
            end
            DECODE: nxt = (dec_cls == C_ILL) ? FAULT : EXEC;
            EXEC: begin
                aluop     = ex_aluop;
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                if (cls_q == C_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = {1'b0, branch_taken};
                    retire   = 1'b1;
                    nxt      = FETCH;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                aluop     = ex_aluop;
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                dmem_req  = 1'b1;
                dmem_we   = (cls_q == C_STORE);
                if (dmem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        nxt      = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end else if (tmo_hit) begin
                    nxt = FAULT;
                end
            end
            WB: begin
                aluop     = ex_aluop;
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                wb_sel    = (cls_q == C_LOAD);
                if (cls_q == C_JAL)
                    pc_sel = 2'd1;
                else if (cls_q == C_JALR)
                    pc_sel = 2'd2;
                nxt = FETCH;
            end
            FAULT: fault = 1'b1;
            default: nxt = RST;
        endcase
    end

    assign state = cur;

endmodule
